// File: rtl/xor_serial_arbiter.sv
// Round-robin arbiter that serialises two requesters' WIDTH-bit XOR operations
// through one shared 1-bit simple_xor gate. Optional parity output: XOR_ARB_PARITY_EN.

module simple_xor (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

// Handshake: a requester raises req[n] with operands stable and holds it until
// grant[n] pulses for one cycle; operands are captured at that accepting edge.
module xor_serial_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic [1:0]       grant,
   output logic             busy,
   output logic [WIDTH-1:0] f,
   output logic             done,
   output logic             done_id,
   output logic             parity,
   output logic [1:0]       state_dbg
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [WIDTH-1:0] a_lat, a_lat_n;
   logic [WIDTH-1:0] b_lat, b_lat_n;
   logic [WIDTH-1:0] acc, acc_n;
   logic             id_lat, id_lat_n;
   logic             last, last_n;
   logic             winner;
   logic [1:0]       grant_n;
   logic             busy_n;
   logic             done_n;
   logic [WIDTH-1:0] f_n;
   logic             done_id_n;
   logic             xor_bit;

   // The only XOR in the datapath: every result bit goes through this gate.
   simple_xor u_xor (
      .a (a_lat[idx]),
      .b (b_lat[idx]),
      .y (xor_bit)
   );

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      a_lat_n   = a_lat;
      b_lat_n   = b_lat;
      acc_n     = acc;
      id_lat_n  = id_lat;
      last_n    = last;
      winner    = 1'b0;
      grant_n   = 2'b00;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      f_n       = f;
      done_id_n = done_id;

      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               // On a tie the requester not served last wins.
               if (req == 2'b11) begin
                  winner = ~last;
               end else begin
                  winner = req[1];
               end
               a_lat_n  = winner ? a1 : a0;
               b_lat_n  = winner ? b1 : b0;
               id_lat_n = winner;
               idx_n    = '0;
               acc_n    = '0;
               grant_n  = winner ? 2'b10 : 2'b01;
               state_n  = SHIFT;
            end
         end
         SHIFT: begin
            acc_n[idx] = xor_bit;
            if (idx == LAST_IDX) begin
               // Publish on the edge into DONE so done/f are visible during DONE.
               state_n   = DONE;
               done_n    = 1'b1;
               f_n       = acc_n;
               done_id_n = id_lat;
            end else begin
               idx_n = idx + IDX_W'(1);
            end
         end
         DONE: begin
            last_n  = id_lat;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         a_lat   <= '0;
         b_lat   <= '0;
         acc     <= '0;
         id_lat  <= 1'b0;
         last    <= 1'b1;
         grant   <= 2'b00;
         busy    <= 1'b0;
         done    <= 1'b0;
         f       <= '0;
         done_id <= 1'b0;
      end else begin
         idx     <= idx_n;
         a_lat   <= a_lat_n;
         b_lat   <= b_lat_n;
         acc     <= acc_n;
         id_lat  <= id_lat_n;
         last    <= last_n;
         grant   <= grant_n;
         busy    <= busy_n;
         done    <= done_n;
         f       <= f_n;
         done_id <= done_id_n;
      end
   end

`ifdef XOR_ARB_PARITY_EN
   logic par_acc, par_acc_n;
   logic parity_q, parity_n;

   always_comb begin
      par_acc_n = par_acc;
      parity_n  = parity_q;
      if (state == IDLE) begin
         par_acc_n = 1'b0;
      end else if (state == SHIFT) begin
         par_acc_n = par_acc ^ xor_bit;
         if (idx == LAST_IDX) begin
            parity_n = par_acc_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         par_acc  <= 1'b0;
         parity_q <= 1'b0;
      end else begin
         par_acc  <= par_acc_n;
         parity_q <= parity_n;
      end
   end

   assign parity = parity_q;
`else
   assign parity = 1'b0;
`endif

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_done_busy:    assert property (@(posedge clk) disable iff (rst) done |-> busy);

endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Directed bench for xor_serial_arbiter: vector table for single operations plus
// hand-written sequences for fairness, reset abort, operand hold-off and WIDTH=1.

module tb_xor_serial_arbiter;

   localparam int W = 8;

   typedef struct {
      logic [1:0]   req;
      logic [W-1:0] a0;
      logic [W-1:0] b0;
      logic [W-1:0] a1;
      logic [W-1:0] b1;
      logic [1:0]   exp_grant;
      logic         exp_id;
      logic [W-1:0] exp_f;
   } vec_t;

   logic         clk;
   logic         rst;
   logic [1:0]   req;
   logic [W-1:0] a0, b0, a1, b1;
   logic [1:0]   grant;
   logic         busy;
   logic [W-1:0] f;
   logic         done;
   logic         done_id;
   logic         parity;
   logic [1:0]   state_dbg;

   logic [1:0]   req_w;
   logic         a0_w, b0_w, a1_w, b1_w;
   logic [1:0]   grant_w;
   logic         busy_w;
   logic         f_w;
   logic         done_w;
   logic         done_id_w;
   logic         parity_w;
   logic [1:0]   state_dbg_w;

   logic [W-1:0] exp_q[$];
   vec_t         vecs[8];
   int           n_cmp;
   int           n_fail;

   xor_serial_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a0        (a0),
      .b0        (b0),
      .a1        (a1),
      .b1        (b1),
      .grant     (grant),
      .busy      (busy),
      .f         (f),
      .done      (done),
      .done_id   (done_id),
      .parity    (parity),
      .state_dbg (state_dbg)
   );

   xor_serial_arbiter #(.WIDTH(1)) dut_w1 (
      .clk       (clk),
      .rst       (rst),
      .req       (req_w),
      .a0        (a0_w),
      .b0        (b0_w),
      .a1        (a1_w),
      .b1        (b1_w),
      .grant     (grant_w),
      .busy      (busy_w),
      .f         (f_w),
      .done      (done_w),
      .done_id   (done_id_w),
      .parity    (parity_w),
      .state_dbg (state_dbg_w)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic exp_par(input logic [W-1:0] v);
`ifdef XOR_ARB_PARITY_EN
      return ^v;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_grant", grant, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_f", f, 8'h00);
      check("rst_done", done, 1'b0);
      check("rst_done_id", done_id, 1'b0);
      check("rst_parity", parity, 1'b0);
      check("rst_state", state_dbg, 2'd0);
      rst = 1'b0;
   endtask

   // Counts negedges until done is seen or the budget runs out.
   task automatic wait_done(input int max_cyc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < max_cyc);
   endtask

   // driver: call on a negedge with the DUT idle; returns on the negedge of the idle cycle.
   task automatic run_op(input vec_t v);
      int n;
      logic [W-1:0] e;
      req = v.req;
      a0  = v.a0;
      b0  = v.b0;
      a1  = v.a1;
      b1  = v.b1;
      exp_q.push_back(v.exp_f);
      @(negedge clk);
      check("grant", grant, v.exp_grant);
      check("busy_c1", busy, 1'b1);
      req = 2'b00;
      wait_done(20, n);
      check("done_cycle", 1 + n, W + 1);
      e = exp_q.pop_front();
      check("f", f, e);
      check("done_id", done_id, v.exp_id);
      check("parity", parity, exp_par(e));
      check("busy_done", busy, 1'b1);
      @(negedge clk);
      check("done_pulse", done, 1'b0);
      check("busy_idle", busy, 1'b0);
   endtask

   task automatic run_w1(input logic a, input logic b, input logic ef);
      req_w = 2'b01;
      a0_w  = a;
      b0_w  = b;
      @(negedge clk);
      check("w1_grant", grant_w, 2'b01);
      req_w = 2'b00;
      @(negedge clk);
      check("w1_done", done_w, 1'b1);
      check("w1_f", f_w, ef);
      check("w1_parity", parity_w, exp_par({{(W-1){1'b0}}, ef}));
      @(negedge clk);
      check("w1_done_pulse", done_w, 1'b0);
      check("w1_busy", busy_w, 1'b0);
   endtask

   initial begin
      int n;
      int ndone;
      int ngrant;
      logic [W-1:0] e;

      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      req    = 2'b00;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      req_w  = 2'b00;
      a0_w = 1'b0; b0_w = 1'b0; a1_w = 1'b0; b1_w = 1'b0;

      vecs[0] = '{2'b11, 8'hFF, 8'h00, 8'h01, 8'h00, 2'b01, 1'b0, 8'hFF};
      vecs[1] = '{2'b11, 8'hFF, 8'h00, 8'h01, 8'h00, 2'b10, 1'b1, 8'h01};
      vecs[2] = '{2'b01, 8'hA5, 8'h0F, 8'h00, 8'h00, 2'b01, 1'b0, 8'hAA};
      vecs[3] = '{2'b10, 8'h00, 8'h00, 8'h12, 8'h34, 2'b10, 1'b1, 8'h26};
      vecs[4] = '{2'b11, 8'h00, 8'h00, 8'hF0, 8'h0F, 2'b01, 1'b0, 8'h00};
      vecs[5] = '{2'b11, 8'h55, 8'hAA, 8'h80, 8'h01, 2'b10, 1'b1, 8'h81};
      vecs[6] = '{2'b10, 8'h00, 8'h00, 8'h3C, 8'hC3, 2'b10, 1'b1, 8'hFF};
      vecs[7] = '{2'b01, 8'h01, 8'h80, 8'h00, 8'h00, 2'b01, 1'b0, 8'h81};

      do_reset();

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i]);
      end

      // fairness: both requesters held continuously across four operations
      do_reset();
      a0 = 8'h11; b0 = 8'h22;
      a1 = 8'h44; b1 = 8'h88;
      exp_q.push_back(8'h33);
      exp_q.push_back(8'hCC);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'hCC);
      req    = 2'b11;
      ndone  = 0;
      ngrant = 0;
      for (int cyc = 1; cyc <= 60 && ndone < 4; cyc++) begin
         @(negedge clk);
         if (grant != 2'b00) begin
            check("fair_grant", grant, (ngrant % 2 == 0) ? 2'b01 : 2'b10);
            check("fair_grant_cyc", cyc, 1 + 10 * ngrant);
            ngrant++;
         end
         if (done) begin
            e = exp_q.pop_front();
            check("fair_done_cyc", cyc, 9 + 10 * ndone);
            check("fair_f", f, e);
            ndone++;
            if (ndone == 4) req = 2'b00;
         end
      end
      check("fair_count", ndone, 4);
      @(negedge clk);

      // reset in cycle 4 of an operation aborts it
      req = 2'b01;
      a0  = 8'hFF;
      b0  = 8'h00;
      @(negedge clk);
      req = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_grant", grant, 2'b00);
      check("abort_busy", busy, 1'b0);
      check("abort_f", f, 8'h00);
      check("abort_done", done, 1'b0);
      check("abort_done_id", done_id, 1'b0);
      check("abort_parity", parity, 1'b0);
      rst = 1'b0;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      run_op('{2'b10, 8'h00, 8'h00, 8'h3C, 8'hC3, 2'b10, 1'b1, 8'hFF});

      // operand hold-off and request during SHIFT
      req = 2'b01;
      a0  = 8'h0F;
      b0  = 8'hF0;
      @(negedge clk);
      check("hold_grant0", grant, 2'b01);
      req = 2'b00;
      @(negedge clk);
      a0  = 8'hFF;
      b0  = 8'hFF;
      a1  = 8'hAA;
      b1  = 8'h00;
      req = 2'b10;
      ngrant = 0;
      n = 2;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
         if (grant != 2'b00) ngrant++;
      end
      check("hold_done_cyc", n, W + 1);
      check("hold_f", f, 8'hFF);
      check("hold_id", done_id, 1'b0);
      check("hold_no_grant", ngrant, 0);
      @(negedge clk);
      check("hold_idle_grant", grant, 2'b00);
      check("hold_idle_busy", busy, 1'b0);
      @(negedge clk);
      check("hold_grant1", grant, 2'b10);
      req = 2'b00;
      wait_done(20, n);
      check("hold2_done_cyc", 1 + n, W + 1);
      check("hold2_f", f, 8'hAA);
      check("hold2_id", done_id, 1'b1);
      @(negedge clk);

      // WIDTH=1 boundary
      run_w1(1'b1, 1'b1, 1'b0);
      run_w1(1'b1, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
